// File: rtl/pc_fetch.sv
// Instruction-fetch stage: owns the PC, drives a one-outstanding req/ack fetch
// port and presents (if_pc, pc_inst) to IF/ID, handling stall, branch and flush.
module pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic [31:0] new_pc,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_ack,
    input  logic [31:0] inst_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] pc_inst,
    output logic        stallreq_if,
    output logic        if_excep_adel
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD,
        DISCARD
    } state_t;

    state_t      state, state_nx;
    logic [31:0] pc, pc_nx;
    logic [31:0] req_addr, req_addr_nx;
    logic [31:0] hold_inst, hold_inst_nx;
    logic        pend_br, pend_br_nx;
    logic [31:0] pend_tgt, pend_tgt_nx;
    logic        advance;
    logic        misaligned;
    logic [31:0] next_pc;

    assign misaligned = (pc[1:0] != 2'b00);
    assign next_pc    = branch_flag ? branch_target :
                        pend_br     ? pend_tgt      : pc + 32'd4;

    // Flush blanks only the IF/ID-facing outputs; inst_req/inst_addr follow
    // the state so an open memory handshake is never withdrawn.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        inst_req      = 1'b0;
        inst_addr     = 32'h0;
        if_pc         = 32'h0;
        pc_inst       = 32'h0;
        stallreq_if   = 1'b0;
        if_excep_adel = 1'b0;
        case (state)
            REQ: begin
                if (misaligned) begin
                    if_pc         = pc;
                    if_excep_adel = 1'b1;
                end else begin
                    inst_req  = 1'b1;
                    inst_addr = req_addr;
                    if (inst_ack) begin
                        if_pc   = pc;
                        pc_inst = inst_rdata;
                    end else begin
                        stallreq_if = 1'b1;
                    end
                end
            end
            HOLD: begin
                if_pc   = pc;
                pc_inst = hold_inst;
            end
            DISCARD: begin
                inst_req    = 1'b1;
                inst_addr   = req_addr;
                stallreq_if = 1'b1;
            end
            default: ;
        endcase
        if (flush) begin
            if_pc         = 32'h0;
            pc_inst       = 32'h0;
            stallreq_if   = 1'b0;
            if_excep_adel = 1'b0;
        end
    end

    always_comb begin
        state_nx     = state;
        pc_nx        = pc;
        req_addr_nx  = req_addr;
        hold_inst_nx = hold_inst;
        pend_br_nx   = pend_br;
        pend_tgt_nx  = pend_tgt;
        advance      = 1'b0;
        if (flush) begin
            pc_nx      = new_pc;
            pend_br_nx = 1'b0;
            // An unanswered request must still be drained; its data is dropped.
            if (inst_req && !inst_ack) begin
                state_nx = DISCARD;
            end else begin
                req_addr_nx = new_pc;
                state_nx    = REQ;
            end
        end else begin
            case (state)
                IDLE: begin
                    req_addr_nx = pc;
                    state_nx    = REQ;
                end
                REQ: begin
                    if (misaligned) begin
                        advance = !stall[0];
                    end else if (inst_ack) begin
                        if (stall[0]) begin
                            hold_inst_nx = inst_rdata;
                            state_nx     = HOLD;
                        end else begin
                            advance = 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (!stall[0]) begin
                        advance  = 1'b1;
                        state_nx = REQ;
                    end
                end
                DISCARD: begin
                    if (inst_ack) begin
                        req_addr_nx = pc;
                        state_nx    = REQ;
                    end
                end
                default: state_nx = IDLE;
            endcase
            if (advance) begin
                pc_nx       = next_pc;
                req_addr_nx = next_pc;
                pend_br_nx  = 1'b0;
            end else if (branch_flag) begin
                pend_br_nx  = 1'b1;
                pend_tgt_nx = branch_target;
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments only; reset is synchronous.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            req_addr  <= 32'h0;
            hold_inst <= 32'h0;
            pend_br   <= 1'b0;
            pend_tgt  <= 32'h0;
        end else begin
            state     <= state_nx;
            pc        <= pc_nx;
            req_addr  <= req_addr_nx;
            hold_inst <= hold_inst_nx;
            pend_br   <= pend_br_nx;
            pend_tgt  <= pend_tgt_nx;
        end
    end

endmodule
